// File: rtl/result_uart_reporter_pkg.sv
// result_report_pkg
//   Shared definitions for the result UART reporter: ASCII constants, message
//   length, FSM state types, the snapshot record and the character generator
//   that turns (index, snapshot) into one byte of the report line.
//
//   Configuration macro: REPORT_CYCLES_EN
//     undefined : "R=xxxxx S=xx H=xxxx\r\n"                (21 chars)
//     defined   : "R=xxxxx S=xx H=xxxx C=xxxxxxxx\r\n"     (32 chars)
package result_report_pkg;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_H  = 8'h48;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef REPORT_CYCLES_EN
  localparam int MSG_LEN = 32;
`else
  localparam int MSG_LEN = 21;
`endif

  // wide enough for either message length
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_SEND,
    RPT_DONE
  } rpt_state_t;

  typedef enum logic [1:0] {
    UTX_IDLE,
    UTX_START,
    UTX_DATA,
    UTX_STOP
  } utx_state_t;

  // Buses are held zero-extended to whole nibbles.
  typedef struct packed {
    logic [19:0] r;
    logic [7:0]  s;
    logic [15:0] h;
`ifdef REPORT_CYCLES_EN
    logic [31:0] c;
`endif
  } snap_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] msg_char(input logic [IDX_W-1:0] idx, input snap_t sn);
    logic [7:0] c;
    c = ASCII_SP;
    case (idx)
      6'd0:  c = ASCII_R;
      6'd1:  c = ASCII_EQ;
      6'd2:  c = hex_ascii(sn.r[19:16]);
      6'd3:  c = hex_ascii(sn.r[15:12]);
      6'd4:  c = hex_ascii(sn.r[11:8]);
      6'd5:  c = hex_ascii(sn.r[7:4]);
      6'd6:  c = hex_ascii(sn.r[3:0]);
      6'd7:  c = ASCII_SP;
      6'd8:  c = ASCII_S;
      6'd9:  c = ASCII_EQ;
      6'd10: c = hex_ascii(sn.s[7:4]);
      6'd11: c = hex_ascii(sn.s[3:0]);
      6'd12: c = ASCII_SP;
      6'd13: c = ASCII_H;
      6'd14: c = ASCII_EQ;
      6'd15: c = hex_ascii(sn.h[15:12]);
      6'd16: c = hex_ascii(sn.h[11:8]);
      6'd17: c = hex_ascii(sn.h[7:4]);
      6'd18: c = hex_ascii(sn.h[3:0]);
`ifdef REPORT_CYCLES_EN
      6'd19: c = ASCII_SP;
      6'd20: c = ASCII_C;
      6'd21: c = ASCII_EQ;
      6'd22: c = hex_ascii(sn.c[31:28]);
      6'd23: c = hex_ascii(sn.c[27:24]);
      6'd24: c = hex_ascii(sn.c[23:20]);
      6'd25: c = hex_ascii(sn.c[19:16]);
      6'd26: c = hex_ascii(sn.c[15:12]);
      6'd27: c = hex_ascii(sn.c[11:8]);
      6'd28: c = hex_ascii(sn.c[7:4]);
      6'd29: c = hex_ascii(sn.c[3:0]);
      6'd30: c = ASCII_CR;
      6'd31: c = ASCII_LF;
`else
      6'd19: c = ASCII_CR;
      6'd20: c = ASCII_LF;
`endif
      default: c = ASCII_SP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/result_uart_reporter_uart_tx_byte.sv
// uart_tx_byte
//   8N1 serialiser for one byte at a time. ready is high when idle and also
//   during the last cycle of the stop bit, so a byte offered then starts its
//   start bit on the very next cycle (back-to-back frames, no idle gap).
//
//   state     | meaning
//   ----------+-------------------------------------------
//   UTX_IDLE  | line idle (tx=1), waiting for valid
//   UTX_START | start bit (tx=0)
//   UTX_DATA  | data bits, LSB first, bit_cnt = bit index
//   UTX_STOP  | stop bit (tx=1)
//
// Ports:
//   clock    system clock
//   reset_n  async active-low reset, forces tx=1
//   data     byte to send, taken when valid && ready
//   valid    byte offered
//   ready    byte will be accepted this cycle
//   tx       serial output, idle high
module uart_tx_byte
  import result_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  utx_state_t       state, state_d;
  logic [CNT_W-1:0] baud, baud_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shreg, shreg_d;
  logic             tx_d;
  logic             baud_wrap;

  assign baud_wrap = (baud == BAUD_LAST);
  assign ready     = (state == UTX_IDLE) || ((state == UTX_STOP) && baud_wrap);

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    case (state)
      UTX_IDLE: begin
        if (valid) begin
          state_d = UTX_START;
          shreg_d = data;
          baud_d  = '0;
        end
      end
      UTX_START: begin
        if (baud_wrap) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          state_d   = UTX_DATA;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      UTX_DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) state_d = UTX_STOP;
          else bit_cnt_d = bit_cnt + 1'b1;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      UTX_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (valid) begin
            state_d = UTX_START;
            shreg_d = data;
          end else begin
            state_d = UTX_IDLE;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      default: state_d = UTX_IDLE;
    endcase

    // tx is registered from the next state so the pin never glitches
    case (state_d)
      UTX_START: tx_d = 1'b0;
      UTX_DATA:  tx_d = shreg_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= UTX_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: rtl/result_uart_reporter.sv
// result_uart_reporter
//   On finish, snapshots the Reduceron result buses and sends one ASCII line
//   "R=xxxxx S=xx H=xxxx\r\n" over a UART TX pin (8N1). One report per rising
//   level of finish; a new report needs finish to be seen low in between.
//
//   Optional macro REPORT_CYCLES_EN appends " C=xxxxxxxx", the number of
//   cycles spent idle and armed since reset (saturating 32-bit).
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   RPT_IDLE | waiting for armed && finish; char 0 handed over on capture
//   RPT_SEND | feeding chars 1..MSG_LEN-1 as the serialiser frees up
//   RPT_DONE | one-cycle done pulse after the final stop bit
//
// Ports:
//   clock    system clock
//   reset_n  async active-low reset
//   r        reduction result (18)
//   s        core state (7)
//   h        heap pointer (15)
//   finish   core finished (level)
//   tx       UART serial output, idle high
//   busy     report in progress
//   done     one-cycle pulse after the last stop bit
module result_uart_reporter
  import result_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [17:0] r,
  input  logic [6:0]  s,
  input  logic [14:0] h,
  input  logic        finish,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  rpt_state_t       state, state_d;
  logic             armed, armed_d;
  logic [IDX_W-1:0] char_idx, char_idx_d;
  logic [IDX_W-1:0] char_next;
  snap_t            snap, snap_d;
  logic             busy_d, done_d;
  logic             tx_valid, tx_ready;
  logic [7:0]       tx_data;

`ifdef REPORT_CYCLES_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cycle_cnt <= '0;
    else if (armed && (state == RPT_IDLE) && (cycle_cnt != 32'hFFFF_FFFF))
      cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  assign char_next = char_idx + IDX_W'(1);

  always_comb begin
    state_d    = state;
    armed_d    = armed;
    char_idx_d = char_idx;
    snap_d     = snap;
    tx_valid   = 1'b0;
    tx_data    = msg_char(char_next, snap);

    if (!finish) armed_d = 1'b1;

    case (state)
      RPT_IDLE: begin
        if (armed && finish) begin
          armed_d    = 1'b0;
          snap_d.r   = {2'b00, r};
          snap_d.s   = {1'b0, s};
          snap_d.h   = {1'b0, h};
`ifdef REPORT_CYCLES_EN
          snap_d.c   = cycle_cnt;
`endif
          // char 0 is always 'R', so it can go out on the capture edge itself
          tx_valid   = 1'b1;
          tx_data    = ASCII_R;
          char_idx_d = '0;
          state_d    = RPT_SEND;
        end
      end
      RPT_SEND: begin
        // ready here only occurs in the final cycle of a stop bit
        if (tx_ready) begin
          if (char_idx == IDX_W'(MSG_LEN - 1)) begin
            char_idx_d = '0;
            state_d    = RPT_DONE;
          end else begin
            tx_valid   = 1'b1;
            char_idx_d = char_next;
          end
        end
      end
      RPT_DONE: state_d = RPT_IDLE;
      default:  state_d = RPT_IDLE;
    endcase

    busy_d = (state_d == RPT_SEND);
    done_d = (state_d == RPT_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RPT_IDLE;
      armed    <= 1'b1;
      char_idx <= '0;
      snap     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      armed    <= armed_d;
      char_idx <= char_idx_d;
      snap     <= snap_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (tx_data),
    .valid   (tx_valid),
    .ready   (tx_ready),
    .tx      (tx)
  );

endmodule

// File: tb/tb_result_uart_reporter.sv
module tb_result_uart_reporter;

  localparam int CPB      = 4;
  localparam int LINE_LEN = 21;
  localparam int LINE_CYC = LINE_LEN * 10 * CPB;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] r       = '0;
  logic [6:0]  s       = '0;
  logic [14:0] h       = '0;
  logic        finish  = 1'b0;
  logic        tx, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  result_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .r       (r),
    .s       (s),
    .h       (h),
    .finish  (finish),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // cycle count and activity monitor
  int cyc = 0;
  always @(posedge clock) cyc++;

  int   t_busy = 0, t_done = 0, busy_len = 0, done_cnt = 0;
  logic busy_q = 1'b0;
  logic tx_at_start = 1'b1;
  always @(negedge clock) begin
    if (busy && !busy_q) begin
      t_busy      = cyc;
      tx_at_start = tx;
    end
    if (busy) busy_len++;
    if (done) begin
      done_cnt++;
      t_done = cyc;
    end
    busy_q = busy;
  end

  // UART receiver, sampling mid-bit; abandons a frame on reset
  byte unsigned rxq[$];
  int           rx_cnt = 0;
  bit           rx_active = 1'b0;
  logic [7:0]   rx_sh = '0;
  int           rx_ferr = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB/2) begin
        if (tx !== 1'b0) rx_ferr++;
      end else if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && (rx_cnt % CPB) == CPB/2) begin
        rx_sh[3'((rx_cnt - CPB) / CPB)] = tx;
      end else if (rx_cnt == 9*CPB + CPB/2) begin
        if (tx !== 1'b1) rx_ferr++;
        rxq.push_back(rx_sh);
      end else if (rx_cnt == 10*CPB - 1) begin
        rx_active = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_busy_seen"}, busy, 1'b1);
  endtask

  task automatic compare_line(input string tag, input string exp);
    check({tag, "_len"}, rxq.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      check($sformatf("%s_char%0d", tag, i), (i < rxq.size()) ? rxq[i] : 8'h00, exp[i]);
  endtask

  task automatic run_line(input string tag, input logic [17:0] rr, input logic [6:0] ss,
                          input logic [14:0] hh, input string exp);
    rxq.delete();
    busy_len = 0;
    r = rr;
    s = ss;
    h = hh;
    finish = 1'b1;
    wait_done(tag, LINE_CYC + 50);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_tx_at_done"}, tx, 1'b1);
    finish = 1'b0;
    tick();
    check({tag, "_done_width"}, done, 1'b0);
    compare_line(tag, exp);
    check({tag, "_latency"}, t_done - t_busy, LINE_CYC);
    check({tag, "_busy_len"}, busy_len, LINE_CYC);
    check({tag, "_start_bit"}, tx_at_start, 1'b0);
  endtask

  int d0;

  initial begin
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_tx", tx, 1'b1);

    run_line("basic", 18'h2ABCD, 7'h5A, 15'h1234, "R=2ABCD S=5A H=1234\r\n");
    run_line("zero",  18'h00000, 7'h00, 15'h0000, "R=00000 S=00 H=0000\r\n");
    run_line("max",   18'h3FFFF, 7'h7F, 15'h7FFF, "R=3FFFF S=7F H=7FFF\r\n");

    // level finish: one line only while held
    rxq.delete();
    d0 = done_cnt;
    r = 18'h00ABC; s = 7'h03; h = 15'h0FED;
    finish = 1'b1;
    repeat (5000) tick();
    check("level_done_count", done_cnt - d0, 1);
    check("level_rx_len", rxq.size(), LINE_LEN);
    check("level_busy_after", busy, 1'b0);
    finish = 1'b0;
    tick();
    finish = 1'b1;
    rxq.delete();
    wait_done("level_rearm", LINE_CYC + 50);
    tick();
    compare_line("level_rearm", "R=00ABC S=03 H=0FED\r\n");
    finish = 1'b0;
    tick();

    // snapshot stability
    rxq.delete();
    r = 18'h00001; s = 7'h11; h = 15'h0022;
    finish = 1'b1;
    wait_busy("snap", 20);
    r = 18'h12345; s = 7'h7E; h = 15'h7ABC;
    repeat (100) tick();
    finish = 1'b0;
    wait_done("snap", LINE_CYC + 50);
    tick();
    compare_line("snap", "R=00001 S=11 H=0022\r\n");

    // reset during char 7 data bits
    rxq.delete();
    r = 18'h0BEEF; s = 7'h2C; h = 15'h4321;
    finish = 1'b1;
    wait_busy("rstmid", 20);
    repeat (7 * 10 * CPB + 2 * CPB) tick();
    check("rstmid_chars_before", rxq.size(), 7);
    reset_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", done, 1'b0);
    repeat (3) tick();
    rxq.delete();
    reset_n = 1'b1;
    wait_done("rstmid", LINE_CYC + 50);
    tick();
    compare_line("rstmid", "R=0BEEF S=2C H=4321\r\n");
    finish = 1'b0;
    repeat (5) tick();

    check("rx_framing_errors", rx_ferr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
